// File: rtl/unary_pkg.sv
// Shared constants and FSM encoding for the unary (thermometer) frame transmitter.
package unary_pkg;

  localparam int DEF_N  = 16;
  localparam int DEF_CW = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int FRAMES_W = 16;

endpackage

// File: rtl/unary_frame_tx.sv
// Serialises a count as an N-bit thermometer frame (ones first), saturating at N.
// First beat one cycle after acceptance; beats hold stable under out_ready backpressure.
module unary_frame_tx
  import unary_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic                out_last,
  output logic                out_ovf,
  output logic [FRAMES_W-1:0] frames_sent
);

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [FRAMES_W-1:0]   frames_q, frames_d;

  logic sending;
  logic in_fire;
  logic beat_fire;
  logic last_beat;

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign sending   = (state_q == ST_SEND);
  assign in_ready  = (state_q == ST_IDLE);
  assign in_fire   = in_valid & in_ready;
  assign beat_fire = sending & out_ready;
  assign last_beat = (idx_q == LAST_C);

  assign out_valid   = sending;
  assign out_bit     = sending & (idx_q < cnt_q);
  assign out_last    = sending & last_beat;
  assign out_ovf     = sending & ovf_q;
  assign frames_sent = frames_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          cnt_d   = (in_count > N_C) ? N_C : in_count;
          ovf_d   = (in_count > N_C);
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_fire) begin
          if (last_beat) begin
            idx_d    = '0;
            frames_d = frames_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_unary_frame_tx.sv
// Randomised scoreboard bench for unary_frame_tx with a popcount loopback on every frame.
module tb_unary_frame_tx;

  localparam int N  = 16;
  localparam int CW = 5;

  typedef struct packed {
    logic b;
    logic l;
    logic o;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;
  logic          out_ovf;
  logic [15:0]   frames_sent;

  unary_frame_tx #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .out_ovf(out_ovf),
    .frames_sent(frames_sent)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    issued = 0;
  int    prev_acc = 0;
  bit    have_prev = 0;
  bit    rand_ready = 0;
  beat_t exp_q[$];
  int    pop_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, idle zeros, deserialise + popcount.
  bit         stall_prev = 0;
  beat_t      stall_beat;
  bit         last_acc = 0;
  logic [15:0] seen_frames = 0;
  logic [N-1:0] sr;
  int         k = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev  = 0;
      last_acc    = 0;
      seen_frames = 0;
      k           = 0;
      sr          = '0;
    end else begin
      if (last_acc) begin
        chk("frames_sent", 32'(frames_sent), 32'(seen_frames));
        last_acc = 0;
      end
      chk("valid_vs_ready", 32'(out_valid), 32'(!in_ready));
      if (!out_valid)
        chk("idle_zero", 32'({out_bit, out_last, out_ovf}), 32'd0);
      if (stall_prev)
        chk("stall_hold", 32'({out_valid, out_bit, out_last, out_ovf}), 32'({1'b1, stall_beat}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", 32'({out_bit, out_last, out_ovf}), 32'(e));
        end
        if (k < N) sr[k] = out_bit;
        k++;
        if (out_last) begin
          if (pop_q.size() == 0)
            chk("unexpected_frame", 32'd1, 32'd0);
          else
            chk("loopback_popcount", 32'($countones(sr)), 32'(pop_q.pop_front()));
          chk("frame_length", 32'(k), 32'(N));
          k = 0;
          sr = '0;
          seen_frames = seen_frames + 16'd1;
          last_acc = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_beat = '{b: out_bit, l: out_last, o: out_ovf};
    end
  end

  task automatic send(input int c, input bit garbage, input bit chk_tp);
    int w;
    int sat;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    sat = (c > N) ? N : c;
    for (int i = 0; i < N; i++)
      exp_q.push_back('{b: (i < sat), l: (i == N - 1), o: (c > N)});
    pop_q.push_back(sat);
    issued++;
    in_valid = 1'b1;
    in_count = CW'(c);
    @(posedge clk);
    #1;
    if (chk_tp && have_prev) chk("b2b_period", 32'(cyc - prev_acc), 32'(N + 1));
    prev_acc  = cyc;
    have_prev = 1;
    chk("first_beat_latency", 32'(out_valid), 32'd1);
    in_valid = garbage;
    if (garbage) begin
      for (int g = 0; g < 3; g++) begin
        in_count = CW'($urandom_range(0, 31));
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({out_bit, out_last, out_ovf}), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed frames with downstream always ready.
    send(5, 1, 0);
    send(0, 1, 0);
    send(16, 1, 0);
    send(20, 1, 0);
    drain();
    chk("frames_after_directed", 32'(frames_sent), 32'd4);

    // Backpressure on a 9-count frame.
    rand_ready = 1;
    send(9, 1, 0);
    send(9, 0, 0);
    drain();
    rand_ready = 0;

    // Full loopback sweep with throughput measurement.
    repeat (2) @(posedge clk);
    have_prev = 0;
    for (int c = 0; c < 32; c++) send(c, 1, 1);
    drain();

    rand_ready = 1;
    for (int r = 0; r < 20; r++) send(int'($urandom_range(0, 31)), 1, 0);
    drain();
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("frames_total", 32'(frames_sent), 32'(issued));

    // Reset while the eighth beat (index 7) is on the wire.
    send(12, 0, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    pop_q.delete();
    issued = 0;
    #1;
    chk("midreset_outputs", 32'({out_valid, out_bit, out_last, out_ovf}), 32'd0);
    chk("midreset_frames", 32'(frames_sent), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_frames", 32'(frames_sent), 32'd0);

    send(3, 0, 0);
    drain();
    chk("recovery_frames", 32'(frames_sent), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unary_frame_tx.md
UNARY_FRAME_TX -- requirements
Module: unary_frame_tx

Interface
REQ-001 SHALL have parameter N, default 16, giving frame length in bits (number of popcount input lanes served).
REQ-002 SHALL have parameter CW, default 5, giving count width; CW = clog2(N+1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  count word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a count.
REQ-007 SHALL have port in_count  input  CW  requested number of ones in the frame.
REQ-008 SHALL have port out_valid  output  1  serial beat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_bit  output  1  current frame bit.
REQ-011 SHALL have port out_last  output  1  marks beat N-1 of the frame.
REQ-012 SHALL have port out_ovf  output  1  current frame was saturated.
REQ-013 SHALL have port frames_sent  output  16  count of completed frames.

Function
REQ-014 SHALL implement FSM states IDLE and SEND only.
REQ-015 SHALL drive in_ready = 1 exactly when state is IDLE (registered state, no combinational path from out_ready).
REQ-016 SHALL, on in_valid & in_ready, latch cnt = min(in_count, N), latch ovf = (in_count > N), clear beat index idx to 0, and enter SEND next cycle.
REQ-017 SHALL, in SEND, hold out_valid = 1 and drive out_bit = (idx < cnt), out_last = (idx == N-1), out_ovf = latched ovf.
REQ-018 SHALL advance idx by 1 only on out_valid & out_ready; out_bit, out_last, out_ovf SHALL remain stable while out_ready = 0.
REQ-019 SHALL, on acceptance of the beat with out_last = 1, return to IDLE and increment frames_sent (wraps 0xFFFF -> 0x0000).
REQ-020 SHALL produce first beat one cycle after input acceptance; with out_ready held high, a frame SHALL occupy N cycles and back-to-back frames SHALL take N+1 cycles each.
REQ-021 SHALL emit thermometer order: all ones first, then zeros; exactly cnt ones per frame (cnt = 0 gives N zeros, cnt = N gives N ones).
REQ-022 SHALL drive out_valid, out_bit, out_last, out_ovf = 0 in IDLE.
REQ-023 SHALL ignore in_valid and in_count while in SEND.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state = IDLE, idx = 0, cnt = 0, ovf = 0, frames_sent = 0, out_valid = out_bit = out_last = out_ovf = 0, in_ready = 1 after release.
REQ-025 SHALL abandon a frame in progress when reset asserts mid-frame; no partial-frame count increment.

Structure
REQ-026 SHALL place FSM state enum and default N/CW constants in shared package unary_pkg.
REQ-027 SHALL be a single module with no sub-modules; idx counter and compare logic inline.

Verification
REQ-028 SHALL check: in_count = 5, out_ready = 1 -> beats 1,1,1,1,1 then 11 zeros, out_last on beat 16, frames_sent = 1.
REQ-029 SHALL check: in_count = 0 -> 16 zeros, out_ovf = 0; in_count = 16 -> 16 ones, out_ovf = 0.
REQ-030 SHALL check: in_count = 20 -> 16 ones, out_ovf = 1 for every beat.
REQ-031 SHALL check: in_count = 9 with out_ready toggling randomly -> same 9 ones/7 zeros sequence, outputs stable during stalls.
REQ-032 SHALL check: rst_n pulsed low at beat 7 of a frame -> all outputs 0 immediately, in_ready = 1 after release, frames_sent = 0.
REQ-033 SHALL check: loopback into a 16-input popcount after deserializing -> decoded count equals min(in_count, 16) for all in_count 0..31.
